// File: rtl/vram_arbiter_if.sv
// Bundle of the VGA reader, pixel writer, frame-clear and RAM-side signals
// around the frame-buffer arbiter.
interface vram_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 12
);
  logic          vga_rdn;
  logic [8:0]    vga_row;
  logic [9:0]    vga_col;
  logic [DW-1:0] vga_data;

  logic          wr_req;
  logic [8:0]    wr_row;
  logic [9:0]    wr_col;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_err;

  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  vga_rdn, vga_row, vga_col,
    input  wr_req, wr_row, wr_col, wr_data,
    input  clr_start, clr_color,
    input  ram_rdata,
    output vga_data, wr_ack, wr_err, clr_busy, clr_done,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vga_rdn, vga_row, vga_col,
    output wr_req, wr_row, wr_col, wr_data,
    output clr_start, clr_color,
    output ram_rdata,
    input  vga_data, wr_ack, wr_err, clr_busy, clr_done,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: VGA scan-out reads always win, the frame
// clear sequencer and then the game pixel writer use the idle (blanking) cycles.
module vram_arbiter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int AW    = 19,
  parameter int DW    = 12
) (
  input  logic          vga_clk,
  input  logic          rst,
  vram_arbiter_if.slave bus
);
  localparam logic [AW-1:0] LAST_PIX = AW'(H_RES * V_RES - 1);
  localparam logic [8:0]    ROW_LIM  = 9'(V_RES);
  localparam logic [9:0]    COL_LIM  = 10'(H_RES);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] clr_color_q;
  logic          clr_busy_q;
  logic          clr_done_q;
  logic          wr_err_q;
  logic          rd_q;
  logic          clr_grant;
  logic          wr_bad;
  logic          wr_in_range;

  // row*H_RES + col as a sum of shifted rows, one term per set bit of H_RES.
  function automatic logic [AW-1:0] lin_addr(input logic [8:0] row, input logic [9:0] col);
    logic [AW-1:0] acc;
    acc = AW'(col);
    for (int i = 0; i < 31; i++)
      if (((H_RES >> i) & 1) != 0) acc = acc + (AW'(row) << i);
    return acc;
  endfunction

  assign wr_in_range = (bus.wr_row < ROW_LIM) && (bus.wr_col < COL_LIM);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.wr_ack    = 1'b0;
    clr_grant     = 1'b0;
    wr_bad        = 1'b0;
    if (!bus.vga_rdn) begin
      bus.ram_addr = lin_addr(bus.vga_row, bus.vga_col);
    end else if (state == CLEAR) begin
      bus.ram_addr  = clr_cnt;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = clr_color_q;
      clr_grant     = 1'b1;
    end else if (state == IDLE && bus.wr_req) begin
      bus.wr_ack = 1'b1;
      if (wr_in_range) begin
        bus.ram_addr  = lin_addr(bus.wr_row, bus.wr_col);
        bus.ram_we    = 1'b1;
        bus.ram_wdata = bus.wr_data;
      end else begin
        wr_bad = 1'b1;
      end
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      clr_color_q <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      rd_q     <= !bus.vga_rdn;
      wr_err_q <= wr_err_q | wr_bad;
      case (state)
        IDLE: if (bus.clr_start) begin
          state       <= CLEAR;
          clr_cnt     <= '0;
          clr_color_q <= bus.clr_color;
          clr_busy_q  <= 1'b1;
        end
        CLEAR: if (clr_grant) begin
          if (clr_cnt == LAST_PIX) begin
            state      <= DONE;
            clr_done_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          clr_done_q <= 1'b0;
          clr_busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM output register already holds last cycle's pixel; only gate it.
  assign bus.vga_data = rd_q ? bus.ram_rdata : '0;
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
  assign bus.wr_err   = wr_err_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a full-size instance for addressing, the
// writer handshake and reset mid-clear, and a small-frame instance for a full clear.
module tb_vram_arbiter;
  localparam int AW = 19;
  localparam int DW = 12;
  localparam int SH = 20;
  localparam int SV = 12;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  vram_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

  vram_arbiter #(.H_RES(640), .V_RES(480), .AW(AW), .DW(DW)) dut (
    .vga_clk(clk), .rst(rst), .bus(bus));
  vram_arbiter #(.H_RES(SH), .V_RES(SV), .AW(AW), .DW(DW)) dut_s (
    .vga_clk(clk), .rst(rst_s), .bus(s_bus));

  // Synchronous RAM models whose read data is the low bits of the address.
  always @(posedge clk) begin
    bus.ram_rdata   <= bus.ram_addr[DW-1:0];
    s_bus.ram_rdata <= s_bus.ram_addr[DW-1:0];
  end

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] s_exp_rd[$];
  wr_t           exp_wr[$];
  wr_t           s_exp_wr[$];
  bit            exp_ack[$];
  bit            s_exp_ack[$];
  bit            prev_rd = 1'b0;
  bit            s_prev_rd = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] s_prev_addr = '0;
  int            done_cnt = 0;
  int            s_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=nothing at %0t", name, act, $time);
  endtask

  // Monitor for the full-size instance.
  always @(negedge clk) begin : mon
    wr_t w;
    bit  e;
    check("vga_data", 32'(bus.vga_data), prev_rd ? 32'(prev_addr[DW-1:0]) : 32'd0);
    prev_rd = 1'b0;
    if (!bus.vga_rdn) begin
      if (exp_rd.size() == 0) flag("unexpected_read", 32'(bus.ram_addr));
      else begin
        prev_addr = exp_rd.pop_front();
        prev_rd   = !rst;
        check("rd_addr", 32'(bus.ram_addr), 32'(prev_addr));
        check("rd_we", 32'(bus.ram_we), 32'd0);
      end
    end
    if (bus.ram_we) begin
      if (exp_wr.size() == 0) flag("unexpected_write", 32'(bus.ram_addr));
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(bus.ram_addr), 32'(w.addr));
        check("wr_data", 32'(bus.ram_wdata), 32'(w.data));
      end
    end
    if (bus.wr_ack) begin
      if (exp_ack.size() == 0) flag("unexpected_ack", 32'(bus.wr_ack));
      else begin
        e = exp_ack.pop_front();
        check("ack_we", 32'(bus.ram_we), 32'(e));
      end
    end
    if (bus.clr_done) done_cnt++;
  end

  // Monitor for the small-frame instance.
  always @(negedge clk) begin : s_mon
    wr_t w;
    bit  e;
    check("s_vga_data", 32'(s_bus.vga_data), s_prev_rd ? 32'(s_prev_addr[DW-1:0]) : 32'd0);
    s_prev_rd = 1'b0;
    if (!s_bus.vga_rdn) begin
      if (s_exp_rd.size() == 0) flag("s_unexpected_read", 32'(s_bus.ram_addr));
      else begin
        s_prev_addr = s_exp_rd.pop_front();
        s_prev_rd   = !rst_s;
        check("s_rd_addr", 32'(s_bus.ram_addr), 32'(s_prev_addr));
        check("s_rd_we", 32'(s_bus.ram_we), 32'd0);
      end
    end
    if (s_bus.ram_we) begin
      if (s_exp_wr.size() == 0) flag("s_unexpected_write", 32'(s_bus.ram_addr));
      else begin
        w = s_exp_wr.pop_front();
        check("s_wr_addr", 32'(s_bus.ram_addr), 32'(w.addr));
        check("s_wr_data", 32'(s_bus.ram_wdata), 32'(w.data));
      end
    end
    if (s_bus.wr_ack) begin
      if (s_exp_ack.size() == 0) flag("s_unexpected_ack", 32'(s_bus.wr_ack));
      else begin
        e = s_exp_ack.pop_front();
        check("s_ack_we", 32'(s_bus.ram_we), 32'(e));
        check("s_ack_after_done", 32'(s_done_cnt), 32'd1);
      end
    end
    if (s_bus.clr_done) s_done_cnt++;
  end

  task automatic cyc(input bit rd, input int row, input int col, output bit ack);
    bus.vga_rdn = !rd;
    bus.vga_row = 9'(row);
    bus.vga_col = 10'(col);
    if (rd) exp_rd.push_back(AW'(row * 640 + col));
    @(negedge clk);
    ack = bus.wr_ack;
    @(posedge clk);
    #1;
  endtask

  task automatic scyc(input bit rd, input int row, input int col, output bit ack);
    s_bus.vga_rdn = !rd;
    s_bus.vga_row = 9'(row);
    s_bus.vga_col = 10'(col);
    if (rd) s_exp_rd.push_back(AW'(row * SH + col));
    @(negedge clk);
    ack = s_bus.wr_ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int row, input int col, input logic [DW-1:0] d,
                          input int pre_reads, input bit ok);
    bit ack;
    int n;
    bus.wr_req  = 1'b1;
    bus.wr_row  = 9'(row);
    bus.wr_col  = 10'(col);
    bus.wr_data = d;
    for (int i = 0; i < pre_reads; i++) begin
      cyc(1'b1, i * 37, i * 61, ack);
      check("ack_blocked_by_vga", 32'(ack), 32'd0);
    end
    exp_ack.push_back(ok);
    if (ok) exp_wr.push_back('{addr: AW'(row * 640 + col), data: d});
    n = 0;
    do begin
      cyc(1'b0, 0, 0, ack);
      n++;
    end while (!ack && n < 50);
    check("ack_timeout", 32'(ack), 32'd1);
    bus.wr_req = 1'b0;
  endtask

  task automatic drain(input int limit);
    bit ack;
    int n;
    n = 0;
    while (exp_wr.size() != 0 && n < limit) begin
      cyc(1'b0, 0, 0, ack);
      n++;
    end
    check("drain_timeout", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit ack;
    int n;
    bus.vga_rdn = 1'b1;   bus.vga_row = '0;   bus.vga_col = '0;
    bus.wr_req = 1'b0;    bus.wr_row = '0;    bus.wr_col = '0;   bus.wr_data = '0;
    bus.clr_start = 1'b0; bus.clr_color = '0;
    s_bus.vga_rdn = 1'b1;   s_bus.vga_row = '0;   s_bus.vga_col = '0;
    s_bus.wr_req = 1'b0;    s_bus.wr_row = '0;    s_bus.wr_col = '0;   s_bus.wr_data = '0;
    s_bus.clr_start = 1'b0; s_bus.clr_color = '0;

    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    rst_s = 1'b0;
    check("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
    check("rst_clr_done", 32'(bus.clr_done), 32'd0);
    check("rst_wr_err", 32'(bus.wr_err), 32'd0);
    check("rst_vga_data", 32'(bus.vga_data), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);

    // VGA reads, including the last pixel of the frame.
    cyc(1'b1, 2, 5, ack);
    cyc(1'b1, 479, 639, ack);
    cyc(1'b1, 0, 0, ack);
    cyc(1'b0, 0, 0, ack);
    cyc(1'b1, 100, 320, ack);
    cyc(1'b0, 0, 0, ack);

    // Writer handshake, in-range and out-of-range.
    do_write(479, 639, 12'hF0F, 10, 1'b1);
    check("wr_err_clean", 32'(bus.wr_err), 32'd0);
    do_write(0, 0, 12'h123, 0, 1'b1);
    do_write(480, 0, 12'h111, 0, 1'b0);
    check("wr_err_row", 32'(bus.wr_err), 32'd1);
    do_write(0, 640, 12'h222, 2, 1'b0);
    do_write(2, 3, 12'h333, 1, 1'b1);
    repeat (3) cyc(1'b0, 0, 0, ack);
    check("wr_err_sticky", 32'(bus.wr_err), 32'd1);

    // Clear requested together with a write: write first, clear from next cycle.
    bus.clr_start = 1'b1;
    bus.clr_color = 12'h0A0;
    bus.wr_req    = 1'b1;
    bus.wr_row    = 9'd1;
    bus.wr_col    = 10'd1;
    bus.wr_data   = 12'h555;
    exp_ack.push_back(1'b1);
    exp_wr.push_back('{addr: AW'(641), data: 12'h555});
    for (int i = 0; i < 1000; i++) exp_wr.push_back('{addr: AW'(i), data: 12'h0A0});
    cyc(1'b0, 0, 0, ack);
    check("start_ack", 32'(ack), 32'd1);
    bus.clr_start = 1'b0;
    bus.wr_req    = 1'b0;
    bus.clr_color = 12'h0FF;
    check("clr_busy_running", 32'(bus.clr_busy), 32'd1);
    drain(3000);

    // Reset after exactly 1000 clear writes; the reset cycle itself is a VGA read.
    rst = 1'b1;
    cyc(1'b1, 7, 8, ack);
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.clr_busy), 32'd0);
    check("mid_rst_done", 32'(bus.clr_done), 32'd0);
    check("mid_rst_wr_err", 32'(bus.wr_err), 32'd0);
    repeat (5) cyc(1'b0, 0, 0, ack);

    // A new clear restarts at address 0.
    for (int i = 0; i < 5; i++) exp_wr.push_back('{addr: AW'(i), data: 12'h3C3});
    bus.clr_start = 1'b1;
    bus.clr_color = 12'h3C3;
    cyc(1'b0, 0, 0, ack);
    bus.clr_start = 1'b0;
    drain(20);
    rst = 1'b1;
    cyc(1'b1, 0, 1, ack);
    rst = 1'b0;
    check("restart_rst_busy", 32'(bus.clr_busy), 32'd0);
    repeat (3) cyc(1'b0, 0, 0, ack);

    // Full clear on the small frame with VGA toggling and a pending write.
    for (int i = 0; i < SH * SV; i++) s_exp_wr.push_back('{addr: AW'(i), data: 12'h0A0});
    s_bus.clr_start = 1'b1;
    s_bus.clr_color = 12'h0A0;
    scyc(1'b0, 0, 0, ack);
    s_bus.clr_start = 1'b0;
    s_bus.clr_color = 12'hBAD;
    s_bus.wr_req    = 1'b1;
    s_bus.wr_row    = 9'd3;
    s_bus.wr_col    = 10'd4;
    s_bus.wr_data   = 12'h777;
    s_exp_wr.push_back('{addr: AW'(3 * SH + 4), data: 12'h777});
    s_exp_ack.push_back(1'b1);
    check("s_busy_running", 32'(s_bus.clr_busy), 32'd1);
    n   = 0;
    ack = 1'b0;
    while (!ack && n < 1000) begin
      s_bus.clr_start = (n == 50);
      scyc(n % 2 == 1, 1, 2, ack);
      n++;
    end
    check("s_ack_timeout", 32'(ack), 32'd1);
    s_bus.wr_req    = 1'b0;
    s_bus.clr_start = 1'b0;
    repeat (4) scyc(1'b0, 0, 0, ack);
    check("s_busy_idle", 32'(s_bus.clr_busy), 32'd0);

    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
    check("s_rd_queue_empty", 32'(s_exp_rd.size()), 32'd0);
    check("s_wr_queue_empty", 32'(s_exp_wr.size()), 32'd0);
    check("s_ack_queue_empty", 32'(s_exp_ack.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd0);
    check("s_done_pulses", 32'(s_done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
